// File: rtl/fp16_pkg.sv
// Shared fp16 field constants and the classifier state encoding.
package fp16_pkg;

  localparam int unsigned FP16_W      = 16;
  localparam int unsigned FP16_SIGN   = 15;
  localparam int unsigned FP16_EXP_HI = 14;
  localparam int unsigned FP16_EXP_LO = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cls_state_t;

endpackage

// File: rtl/fp16_pos_gt.sv
// Combinational test: candidate is a positive normal strictly greater than best.
module fp16_pos_gt
  import fp16_pkg::*;
(
  input  logic [FP16_W-1:0] cand,
  input  logic [FP16_W-1:0] best,
  output logic              gt
);

  logic cand_pos_norm;

  // Magnitude bits order correctly for positive values, exponent 31 included.
  assign cand_pos_norm = !cand[FP16_SIGN] && (cand[FP16_EXP_HI:FP16_EXP_LO] != '0);
  assign gt = cand_pos_norm && (cand[FP16_SIGN-1:0] > best[FP16_SIGN-1:0]);

endmodule

// File: rtl/fp16_softmax_classifier.sv
// Captures a softmax fp16 vector, scans it serially and reports the 1-based argmax.
module fp16_softmax_classifier
  import fp16_pkg::*;
#(
  parameter int unsigned IN_OUT_NUM = 10,
  parameter int unsigned IDX_W      = $clog2(IN_OUT_NUM + 1)
) (
  input  logic                         clk,
  input  logic                         reset_b,
  input  logic                         softmax_valid,
  input  logic [IN_OUT_NUM*FP16_W-1:0] softmax_out,
  output logic                         softmax_clear,
  output logic                         class_valid,
  output logic [IDX_W-1:0]             class_idx,
  output logic [FP16_W-1:0]            class_val,
  input  logic                         class_ack,
  output logic                         busy
);

  localparam int unsigned CNT_W = (IN_OUT_NUM > 1) ? $clog2(IN_OUT_NUM) : 1;

  cls_state_t                            state;
  logic [IN_OUT_NUM-1:0][FP16_W-1:0]     buf_q;
  logic [CNT_W-1:0]                      cnt;
  logic                                  armed;
  logic [FP16_W-1:0]                     best_val;
  logic [IDX_W-1:0]                      best_idx;
  logic [FP16_W-1:0]                     cur;
  logic                                  cur_gt;
  logic [IDX_W-1:0]                      cur_idx;
  logic                                  last;

  assign cur     = buf_q[cnt];
  assign cur_idx = IDX_W'(cnt) + IDX_W'(1);
  assign last    = (cnt == CNT_W'(IN_OUT_NUM - 1));

  fp16_pos_gt u_pos_gt (
    .cand (cur),
    .best (best_val),
    .gt   (cur_gt)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state         <= IDLE;
      buf_q         <= '0;
      cnt           <= '0;
      armed         <= 1'b1;
      best_val      <= '0;
      best_idx      <= '0;
      softmax_clear <= 1'b0;
      class_valid   <= 1'b0;
      class_idx     <= '0;
      class_val     <= '0;
      busy          <= 1'b0;
    end else begin
      softmax_clear <= 1'b0;
      // Valid is level-held by the softmax, so only a low sample re-arms capture.
      if (!softmax_valid) armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (softmax_valid && armed) begin
            buf_q         <= softmax_out;
            cnt           <= '0;
            best_val      <= '0;
            best_idx      <= '0;
            armed         <= 1'b0;
            softmax_clear <= 1'b1;
            busy          <= 1'b1;
            state         <= SCAN;
          end
        end
        SCAN: begin
          if (cur_gt) begin
            best_val <= cur;
            best_idx <= cur_idx;
          end
          if (last) begin
            cnt         <= '0;
            class_valid <= 1'b1;
            class_idx   <= cur_gt ? cur_idx : best_idx;
            class_val   <= cur_gt ? cur : best_val;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (class_ack) begin
            class_valid <= 1'b0;
            class_idx   <= '0;
            class_val   <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_softmax_classifier.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor checks them.
module tb_fp16_softmax_classifier;

  localparam int N = 10;
  localparam int IW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            reset_b = 1'b0;
  logic            softmax_valid = 1'b0;
  logic [N*16-1:0] softmax_out = '0;
  logic            softmax_clear;
  logic            class_valid;
  logic [IW-1:0]   class_idx;
  logic [15:0]     class_val;
  logic            class_ack = 1'b0;
  logic            busy;

  typedef struct {
    int          idx;
    logic [15:0] val;
    int          rise_cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  logic [15:0] vec [N];

  fp16_softmax_classifier #(.IN_OUT_NUM(N)) dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .softmax_valid (softmax_valid),
    .softmax_out   (softmax_out),
    .softmax_clear (softmax_clear),
    .class_valid   (class_valid),
    .class_idx     (class_idx),
    .class_val     (class_val),
    .class_ack     (class_ack),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " clear"}, 32'(softmax_clear), 0);
    chk({tag, " class_valid"}, 32'(class_valid), 0);
    chk({tag, " class_idx"}, 32'(class_idx), 0);
    chk({tag, " class_val"}, 32'(class_val), 0);
    chk({tag, " busy"}, 32'(busy), 0);
  endtask

  // Drive vec, let the capture edge pass, check the clear pulse, optionally drop valid.
  task automatic send(input int exp_idx, input logic [15:0] exp_val, input bit push,
                      input bit drop);
    exp_t e;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) softmax_out[i*16 +: 16] = vec[i];
    softmax_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (push) begin
      e.idx = exp_idx; e.val = exp_val; e.rise_cyc = cyc + N;
      sb.push_back(e);
    end
    chk("clear after capture", 32'(softmax_clear), 1);
    chk("busy after capture", 32'(busy), 1);
    if (drop) softmax_valid = 1'b0;
    @(negedge clk);
    chk("clear one cycle only", 32'(softmax_clear), 0);
  endtask

  task automatic wait_and_ack(input int delay);
    int n = 0;
    while (!class_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!class_valid) chk("class_valid timeout", 0, 1);
    repeat (delay) @(negedge clk);
    @(posedge clk); #1 class_ack = 1'b1;
    @(posedge clk); #1 class_ack = 1'b0;
    @(negedge clk);
    chk("class_valid after ack", 32'(class_valid), 0);
  endtask

  // Monitor: compare on each rising class_valid, then check the result holds steady.
  logic        prev_cv = 1'b0;
  logic [15:0] held_val;
  int          held_idx;
  always @(negedge clk) begin
    exp_t e;
    if (class_valid && !prev_cv) begin
      if (sb.size() == 0) begin
        chk("unexpected result", 32'(class_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("class_idx", 32'(class_idx), 32'(e.idx));
        chk("class_val", 32'(class_val), 32'(e.val));
        chk("result latency", 32'(cyc), 32'(e.rise_cyc));
      end
      held_idx = int'(class_idx);
      held_val = class_val;
    end else if (class_valid && prev_cv) begin
      chk("class_idx stable", 32'(class_idx), 32'(held_idx));
      chk("class_val stable", 32'(class_val), 32'(held_val));
    end
    prev_cv = class_valid;
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1 reset_b = 1'b1;

    // Basic winner at index 3
    foreach (vec[i]) vec[i] = 16'h0000;
    vec[0] = 16'h2E66; vec[1] = 16'h3400; vec[2] = 16'h3C00; vec[3] = 16'h3800;
    send(3, 16'h3C00, 1, 1);
    wait_and_ack(0);

    // Tie between 1-based elements 2 and 7 keeps the lower index
    foreach (vec[i]) vec[i] = 16'h3400;
    vec[1] = 16'h3800; vec[6] = 16'h3800;
    send(2, 16'h3800, 1, 1);
    wait_and_ack(0);

    // Zero, negative and denormal only: no winner
    for (int i = 0; i < N; i++) begin
      case (i % 4)
        0: vec[i] = 16'h0000;
        1: vec[i] = 16'h8000;
        2: vec[i] = 16'hBC00;
        default: vec[i] = 16'h0001;
      endcase
    end
    send(0, 16'h0000, 1, 1);
    wait_and_ack(0);

    // Valid held through DONE and ack: exactly one capture
    foreach (vec[i]) vec[i] = 16'h3000;
    vec[4] = 16'h3555;
    send(5, 16'h3555, 1, 0);
    wait_and_ack(0);
    repeat (15) @(negedge clk);
    chk("no recapture busy", 32'(busy), 0);
    @(posedge clk); #1 softmax_valid = 1'b0;
    foreach (vec[i]) vec[i] = 16'h3000;
    vec[8] = 16'h7C00;
    send(9, 16'h7C00, 1, 1);

    // Delayed ack (monitor checks stability), then ack in IDLE is ignored
    wait_and_ack(5);
    @(posedge clk); #1 class_ack = 1'b1;
    @(posedge clk); #1 class_ack = 1'b0;
    @(negedge clk);
    chk("idle ack class_valid", 32'(class_valid), 0);
    chk("idle ack busy", 32'(busy), 0);

    // Asynchronous reset mid-scan, then a fresh result
    foreach (vec[i]) vec[i] = 16'h3C00;
    send(0, 16'h0000, 0, 1);
    repeat (3) @(posedge clk);
    #2 reset_b = 1'b0;
    #1 chk_outputs_zero("async reset");
    @(posedge clk); #1 reset_b = 1'b1;
    foreach (vec[i]) vec[i] = 16'h3800;
    vec[9] = 16'h3A00;
    send(10, 16'h3A00, 1, 1);
    wait_and_ack(0);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
